// File: rtl/sram_bist_sequencer.sv
// BIST master for the SRAM controller: writes an address-derived pattern over
// [START_ADDR, END_ADDR], reads it back, and records mismatch statistics.
module sram_bist_sequencer #(
  parameter int unsigned           ADDR_W     = 18,
  parameter int unsigned           DATA_W     = 16,
  parameter logic [ADDR_W-1:0]     START_ADDR = '0,
  parameter logic [ADDR_W-1:0]     END_ADDR   = '1,
  parameter logic [DATA_W-1:0]     SEED       = 16'hA5A5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [DATA_W-1:0] err_data_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] data_write_o,
  output logic              write_o,
  output logic              read_o,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_read_i
);

  typedef enum logic [3:0] {
    IDLE, WR_REQ, WR_SETTLE, WR_WAIT, RD_REQ, RD_SETTLE, RD_WAIT, CHECK, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, eaddr_q, eaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, cap_q, cap_d, edata_q, edata_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              write_c, read_c;

  // Address bits above DATA_W fold back onto the low data bits.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = SEED;
    for (int i = 0; i < int'(ADDR_W); i++) p[i % int'(DATA_W)] ^= a[i];
    return p;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      eaddr_q <= '0;
      edata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      eaddr_q <= eaddr_d;
      edata_q <= edata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    eaddr_d = eaddr_q;
    edata_d = edata_q;
    write_c = 1'b0;
    read_c  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = WR_REQ;
          addr_d  = START_ADDR;
          wdata_d = pat(START_ADDR);
          cnt_d   = '0;
          eaddr_d = '0;
          edata_d = '0;
        end
      end
      WR_REQ: begin
        if (ready_i) begin
          write_c = 1'b1;
          state_d = WR_SETTLE;
        end
      end
      WR_SETTLE: state_d = WR_WAIT;
      WR_WAIT: begin
        // Compare before increment so END_ADDR = all-ones never wraps.
        if (ready_i) begin
          if (addr_q == END_ADDR) begin
            addr_d  = START_ADDR;
            state_d = RD_REQ;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            wdata_d = pat(addr_q + ADDR_W'(1));
            state_d = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (ready_i) begin
          read_c  = 1'b1;
          state_d = RD_SETTLE;
        end
      end
      RD_SETTLE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (ready_i) begin
          cap_d   = data_read_i;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cap_q != pat(addr_q)) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd0) begin
            eaddr_d = addr_q;
            edata_d = cap_q;
          end
        end
        if (addr_q == END_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o       = (state_q != IDLE) && (state_q != DONE);
  assign done_o       = (state_q == DONE);
  assign pass_o       = done_o && (cnt_q == 16'd0);
  assign err_count_o  = cnt_q;
  assign err_addr_o   = eaddr_q;
  assign err_data_o   = edata_q;
  assign address_o    = addr_q;
  assign data_write_o = wdata_q;
  assign write_o      = write_c;
  assign read_o       = read_c;

endmodule

// File: tb/tb_sram_bist_sequencer.sv
// Bench for sram_bist_sequencer: behavioural controller/SRAM with fault injection,
// request scoreboard and end-of-test result queue.
module tb_sram_bist_sequencer;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int BUDGET = 5000;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } req_t;
  typedef struct { logic pass; logic [15:0] cnt; logic [AW-1:0] ea; logic [DW-1:0] ed; } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;
  logic busy, done, pass, wr, rd, ready;
  logic [15:0] ecnt;
  logic [AW-1:0] eaddr, addr;
  logic [DW-1:0] edata, wdata, rdata;
  logic busy2, done2, pass2, wr2, rd2, ready2;
  logic [15:0] ecnt2;
  logic [AW-1:0] eaddr2, addr2;
  logic [DW-1:0] edata2, wdata2, rdata2;

  sram_bist_sequencer #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(18'd0), .END_ADDR(18'd15),
                        .SEED(16'hA5A5)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(ecnt), .err_addr_o(eaddr), .err_data_o(edata), .address_o(addr),
    .data_write_o(wdata), .write_o(wr), .read_o(rd), .ready_i(ready), .data_read_i(rdata));

  sram_bist_sequencer #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(18'h3FFFF), .END_ADDR(18'h3FFFF),
                        .SEED(16'hA5A5)) dut2 (
    .clk_i(clk), .reset_i(rst), .start_i(start2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_count_o(ecnt2), .err_addr_o(eaddr2), .err_data_o(edata2), .address_o(addr2),
    .data_write_o(wdata2), .write_o(wr2), .read_o(rd2), .ready_i(ready2), .data_read_i(rdata2));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tpat(input logic [17:0] a);
    return 16'hA5A5 ^ a[15:0] ^ {14'b0, a[17:16]};
  endfunction

  // Controller + SRAM model: ready drops for lat cycles after each request.
  // alias1 is a read-decoder fault (read addr bit 1 forced to 0); stuck5 forces bit 3 at addr 5.
  int lat = 2;
  bit stuck5 = 1'b0, alias1 = 1'b0;
  int cnt_r = 0;
  logic [DW-1:0] mem [16];
  logic [3:0] ra;
  assign ready = (cnt_r == 0);
  assign ra = alias1 ? {addr[3:2], 1'b0, addr[0]} : addr[3:0];

  always @(posedge clk) begin
    if (cnt_r > 0) cnt_r <= cnt_r - 1;
    if (ready && wr) begin
      mem[addr[3:0]] <= wdata;
      cnt_r <= lat;
    end
    if (ready && rd) begin
      rdata <= mem[ra] | ((stuck5 && addr == 18'd5) ? 16'h0008 : 16'h0000);
      cnt_r <= lat;
    end
  end

  // Single-word model for the second instance, always ready.
  logic [DW-1:0] mem2;
  assign ready2 = 1'b1;
  always @(posedge clk) begin
    if (wr2) mem2 <= wdata2;
    if (rd2) rdata2 <= mem2;
  end

  req_t wq[$], rq[$];
  res_t resq[$];
  int nwr = 0, nrd = 0, nwr2 = 0, nrd2 = 0;
  bit prev = 1'b0;

  always @(negedge clk) begin
    req_t e;
    if (wr) begin
      nwr++;
      check("wr_rd_overlap", {31'b0, rd}, 0);
      check("wr_back_to_back", {31'b0, prev}, 0);
      if (wq.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = wq.pop_front();
        check("wr_addr", addr, e.a);
        check("wr_data", wdata, e.d);
      end
    end
    if (rd) begin
      nrd++;
      check("rd_back_to_back", {31'b0, prev}, 0);
      if (rq.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        check("rd_addr", addr, e.a);
      end
    end
    prev = wr | rd;
    if (wr2) begin nwr2++; check("wr2_addr", addr2, 18'h3FFFF); end
    if (rd2) begin nrd2++; check("rd2_addr", addr2, 18'h3FFFF); end
  end

  task automatic push_seq(input res_t r);
    for (int a = 0; a < 16; a++) begin
      wq.push_back('{a: 18'(a), d: tpat(18'(a))});
      rq.push_back('{a: 18'(a), d: 16'h0});
    end
    resq.push_back(r);
    nwr = 0;
    nrd = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 1);
  endtask

  task automatic wait_done_check(input string tag);
    res_t r;
    int n = 0;
    while (!done && n < BUDGET) begin @(negedge clk); n++; end
    check({tag, "_done"}, {31'b0, done}, 1);
    if (resq.size() == 0) check({tag, "_noexp"}, 1, 0);
    else begin
      r = resq.pop_front();
      check({tag, "_pass"}, {31'b0, pass}, {31'b0, r.pass});
      check({tag, "_errcnt"}, ecnt, r.cnt);
      check({tag, "_erraddr"}, eaddr, r.ea);
      check({tag, "_errdata"}, edata, r.ed);
    end
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_nwr"}, nwr, 16);
    check({tag, "_nrd"}, nrd, 16);
    check({tag, "_qempty"}, wq.size() + rq.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {26'b0, busy, done, pass, wr, rd, 1'b0}, 0);
    check({tag, "_ecnt"}, ecnt, 0);
    check({tag, "_eaddr"}, eaddr, 0);
    check({tag, "_edata"}, edata, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_wdata"}, wdata, 0);
  endtask

  initial begin
    int n;
    int snap;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // 1: clean run
    push_seq('{pass: 1'b1, cnt: 16'd0, ea: 18'd0, ed: 16'd0});
    pulse_start();
    wait_done_check("clean");

    // 2: stuck bit 3 at address 5 (restart from DONE)
    stuck5 = 1'b1;
    push_seq('{pass: 1'b0, cnt: 16'd1, ea: 18'd5, ed: tpat(18'd5) | 16'h0008});
    pulse_start();
    wait_done_check("stuck");
    stuck5 = 1'b0;

    // 3: read address bit 1 tied low: 2,3,6,7,... alias onto 0,1,4,5,...
    alias1 = 1'b1;
    push_seq('{pass: 1'b0, cnt: 16'd8, ea: 18'd2, ed: tpat(18'd0)});
    pulse_start();
    wait_done_check("alias");
    alias1 = 1'b0;

    // 4: slow controller
    lat = 20;
    push_seq('{pass: 1'b1, cnt: 16'd0, ea: 18'd0, ed: 16'd0});
    pulse_start();
    wait_done_check("slow");
    lat = 2;

    // 5: reset during read pass at address 7, then restart
    push_seq('{pass: 1'b1, cnt: 16'd0, ea: 18'd0, ed: 16'd0});
    pulse_start();
    n = 0;
    while (!(rd && addr == 18'd7) && n < BUDGET) begin @(negedge clk); n++; end
    check("abort_reached_rd7", {31'b0, rd}, 1);
    #2;
    rst = 1'b1;
    wq.delete(); rq.delete(); resq.delete();
    snap = nwr + nrd;
    #1 check_reset_vals("abort_async");
    @(posedge clk) #1 check_reset_vals("abort_edge");
    repeat (5) @(negedge clk);
    check("abort_no_pulses", nwr + nrd, snap);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    push_seq('{pass: 1'b1, cnt: 16'd0, ea: 18'd0, ed: 16'd0});
    pulse_start();
    wait_done_check("restart");

    // 6: single-address range at the top of the address space
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    n = 0;
    while (!done2 && n < BUDGET) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("top_done", {31'b0, done2}, 1);
    check("top_pass", {31'b0, pass2}, 1);
    check("top_errcnt", ecnt2, 0);
    check("top_nwr", nwr2, 1);
    check("top_nrd", nrd2, 1);
    check("top_addr_nowrap", addr2, 18'h3FFFF);
    check("top_wdata", wdata2, tpat(18'h3FFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
